// File: rtl/perceptron_mac.sv
// rtl/perceptron_mac.sv - sequential multiply-accumulate with step activation for one perceptron neuron
module perceptron_mac #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [N_INPUTS*DATA_W-1:0]   in_data,
  input  logic                         w_we,
  input  logic [$clog2(N_INPUTS+1)-1:0] w_addr,
  input  logic [WEIGHT_W-1:0]          w_data,
  output logic                         w_busy,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [ACC_W-1:0]             out_acc,
  output logic                         out_y
);

  localparam int AW = $clog2(N_INPUTS + 1);
  localparam int IW = $clog2(N_INPUTS);
  localparam int PW = DATA_W + WEIGHT_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, state_next;

  logic signed [WEIGHT_W-1:0] w_reg [N_INPUTS];
  logic signed [WEIGHT_W-1:0] bias;
  logic signed [DATA_W-1:0]   x_reg [N_INPUTS];
  logic signed [ACC_W-1:0]    acc;
  logic [IW-1:0]              idx;
  logic signed [PW-1:0]       prod;
  logic [WEIGHT_W-1:0]        bias_src;
  logic                       w_ok;
  logic                       bias_hit;

  assign w_ok     = w_we & ~reset & (state != ACCUM);
  assign bias_hit = w_ok & (w_addr == AW'(N_INPUTS));
  // A bias write coinciding with the input handshake must seed this vector's accumulator.
  assign bias_src = bias_hit ? w_data : bias;
  assign prod     = x_reg[idx] * w_reg[idx];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_rdy     = 1'b0;
    w_busy     = 1'b0;
    out_val    = 1'b0;
    out_acc    = '0;
    out_y      = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = ~reset;
        if (in_val && !reset) state_next = ACCUM;
      end
      ACCUM: begin
        w_busy = ~reset;
        if (idx == IW'(N_INPUTS - 1)) state_next = DONE;
      end
      DONE: begin
        out_val = ~reset;
        out_acc = reset ? '0 : acc;
        out_y   = ~reset & ~acc[ACC_W-1];
        if (out_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        w_reg[i] <= '0;
        x_reg[i] <= '0;
      end
      bias <= '0;
      acc  <= '0;
      idx  <= '0;
    end else begin
      if (w_ok && (w_addr < AW'(N_INPUTS))) w_reg[w_addr[IW-1:0]] <= w_data;
      if (bias_hit) bias <= w_data;
      if (state == IDLE && in_val) begin
        for (int i = 0; i < N_INPUTS; i++) x_reg[i] <= in_data[i*DATA_W +: DATA_W];
        acc <= {{(ACC_W-WEIGHT_W){bias_src[WEIGHT_W-1]}}, bias_src};
        idx <= '0;
      end else if (state == ACCUM) begin
        acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_perceptron_mac.sv
// tb/tb_perceptron_mac.sv - self-checking bench for perceptron_mac
module tb_perceptron_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_data;
  logic        w_we;
  logic [2:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_busy;
  logic        out_val;
  logic        out_rdy;
  logic [19:0] out_acc;
  logic        out_y;

  int pass_cnt = 0;
  int total_cnt = 0;

  perceptron_mac dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_busy(w_busy),
    .out_val(out_val), .out_rdy(out_rdy), .out_acc(out_acc), .out_y(out_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic [7:0]  b;
    logic [31:0] x;
    int          exp_acc;
    int          exp_y;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int model(input logic [31:0] w, input logic [7:0] b, input logic [31:0] x);
    int s;
    s = int'($signed(b));
    for (int i = 0; i < 4; i++) s += int'($signed(w[i*8 +: 8])) * int'($signed(x[i*8 +: 8]));
    return s;
  endfunction

  task automatic write_w(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk) #1;
    w_we = 1'b1; w_addr = a; w_data = d;
    @(posedge clk) #1;
    w_we = 1'b0;
  endtask

  task automatic load(input logic [31:0] w, input logic [7:0] b);
    for (int i = 0; i < 4; i++) write_w(3'(i), w[i*8 +: 8]);
    write_w(3'd4, b);
  endtask

  task automatic send(input logic [31:0] xd, output int acc, output int y, output int lat);
    int guard;
    @(posedge clk) #1;
    in_val = 1'b1; in_data = xd;
    guard = 0;
    @(negedge clk);
    while (!in_rdy && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) check("in_rdy_timeout", 0, 1);
    @(posedge clk) #1;
    in_val = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_val && lat < 50);
    acc = $signed(out_acc);
    y = int'(out_y);
  endtask

  vec_t tbl [5];
  int   acc, y, lat, exp_v, guard;
  bit   stable;
  logic [31:0] rw, rx;
  logic [7:0]  rb;

  initial begin
    reset = 1'b1; in_val = 1'b0; in_data = '0; w_we = 1'b0; w_addr = '0; w_data = '0; out_rdy = 1'b1;

    tbl[0] = '{32'h04030201, 8'hE2, 32'h04030201, 0, 1};
    tbl[1] = '{32'h04030201, 8'hE2, 32'h01010101, -20, 0};
    tbl[2] = '{32'h04030201, 8'h14, 32'h01010101, 30, 1};
    tbl[3] = '{32'h80808080, 8'h00, 32'h80808080, 65536, 1};
    tbl[4] = '{32'h80808080, 8'h00, 32'h7F7F7F7F, -65024, 0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_rdy", int'(in_rdy), 0);
    check("reset_w_busy", int'(w_busy), 0);
    check("reset_out_val", int'(out_val), 0);
    check("reset_out_acc", int'(out_acc), 0);
    check("reset_out_y", int'(out_y), 0);
    @(posedge clk) #1;
    reset = 1'b0;
    @(negedge clk);
    check("first_in_rdy", int'(in_rdy), 1);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      load(tbl[i].w, tbl[i].b);
      send(tbl[i].x, acc, y, lat);
      check($sformatf("tbl%0d_acc", i), acc, tbl[i].exp_acc);
      check($sformatf("tbl%0d_y", i), y, tbl[i].exp_y);
      check($sformatf("tbl%0d_latency", i), lat, 5);
    end

    // Random vectors against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      rw = $urandom; rb = 8'($urandom); rx = $urandom;
      exp_v = model(rw, rb, rx);
      load(rw, rb);
      send(rx, acc, y, lat);
      check($sformatf("rnd%0d_acc", i), acc, exp_v);
      check($sformatf("rnd%0d_y", i), y, (exp_v >= 0) ? 1 : 0);
    end

    // Backpressure: hold result in DONE while a new vector waits
    load(32'h04030201, 8'hE2);
    @(posedge clk) #1;
    out_rdy = 1'b0; in_val = 1'b1; in_data = 32'h04030201;
    @(posedge clk) #1;
    in_data = 32'h01010101;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!out_val && guard < 50);
    check("bp_first_acc", int'($signed(out_acc)), 0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_val || out_acc != 20'd0 || !out_y || in_rdy) stable = 1'b0;
    end
    check("bp_stable", int'(stable), 1);
    @(posedge clk) #1;
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_rdy_after", int'(in_rdy), 1);
    @(posedge clk) #1;
    in_val = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_val && lat < 50);
    check("bp_second_acc", int'($signed(out_acc)), -20);
    check("bp_second_latency", lat, 5);

    // Weight write during ACCUM is dropped
    load(32'h04030201, 8'hE2);
    @(posedge clk) #1;
    in_val = 1'b1; in_data = 32'h04030201;
    @(posedge clk) #1;
    in_val = 1'b0;
    @(posedge clk) #1;
    w_we = 1'b1; w_addr = 3'd0; w_data = 8'd100;
    @(negedge clk);
    check("accum_w_busy", int'(w_busy), 1);
    @(posedge clk) #1;
    w_we = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!out_val && guard < 50);
    check("accum_write_acc", int'($signed(out_acc)), 0);
    send(32'h00000001, acc, y, lat);
    check("accum_write_w0_kept", acc, -29);

    // Reset mid-ACCUM
    @(posedge clk) #1;
    in_val = 1'b1; in_data = 32'h04030201;
    @(posedge clk) #1;
    in_val = 1'b0;
    @(posedge clk) #1;
    reset = 1'b1; w_we = 1'b1; w_addr = 3'd4; w_data = 8'd9;
    @(negedge clk);
    check("midrst_w_busy", int'(w_busy), 0);
    check("midrst_in_rdy", int'(in_rdy), 0);
    check("midrst_out_val", int'(out_val), 0);
    @(posedge clk) #1;
    @(posedge clk) #1;
    reset = 1'b0; w_we = 1'b0;
    @(negedge clk);
    check("midrst_in_rdy_after", int'(in_rdy), 1);
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_val) stable = 1'b0;
    end
    check("midrst_no_emit", int'(stable), 1);
    send(32'h04030201, acc, y, lat);
    check("midrst_zero_acc", acc, 0);
    check("midrst_zero_y", y, 1);

    // Write on the handshake cycle is seen; out-of-range address is ignored
    load(32'h04030201, 8'h00);
    write_w(3'd5, 8'd50);
    @(posedge clk) #1;
    in_val = 1'b1; in_data = 32'h04030201;
    w_we = 1'b1; w_addr = 3'd4; w_data = 8'd5;
    @(posedge clk) #1;
    in_val = 1'b0; w_we = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_val && lat < 50);
    check("same_cycle_bias_acc", int'($signed(out_acc)), 35);
    check("same_cycle_latency", lat, 5);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
